// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Shares one single-port 2048x32 L1 cache BRAM between the instruction-fetch
//   port (if_*) and the data load/store bus (d_*). One access is granted per
//   cycle. Every grant gets exactly one response pulse (rvalid or err) in the
//   following cycle.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - a conflict is won by the requester not granted most recently.
//   undefined - fixed priority: the data port always wins a conflict.
//
// Ports
//   clk_i, reset_i              clock, asynchronous active-high reset
//   if_req_i / if_addr_i        fetch request, byte address (held until if_gnt_o)
//   if_gnt_o                    fetch grant (combinational)
//   if_rvalid_o / if_rdata_o    fetch response, byte-swapped BRAM word
//   if_err_o                    fetch address fault (replaces if_rvalid_o)
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i           data request (held until d_gnt_o)
//   d_gnt_o                     data grant (combinational)
//   d_rvalid_o / d_rdata_o      load data or store ack (rdata 0 on store ack)
//   d_err_o                     data address fault (replaces d_rvalid_o)
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_wdata_o     BRAM control, word-indexed address
//   mem_rdata_i                 BRAM read data, one-cycle latency
//   conflict_cnt_o              saturating count of cycles with both requests high
module cache_port_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [63:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    output logic              if_err_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [63:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [3:0]        d_be_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRespIf,
        StRespD,
        StErrIf,
        StErrD
    } state_e;

    state_e           state_q, state_d;
    logic             store_q, store_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;

    logic if_fault, d_fault;
    logic pick_if, pick_d;
    logic conflict;

    // Out of range above the array, or not word aligned.
    assign if_fault = (|if_addr_i[63:ADDR_W+2]) | (|if_addr_i[1:0]);
    assign d_fault  = (|d_addr_i[63:ADDR_W+2]) | (|d_addr_i[1:0]);
    assign conflict = if_req_i & d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr_q == 0 favours fetch, 1 favours data.
    logic rr_ptr_q;

    assign pick_if = if_req_i & (~d_req_i | ~rr_ptr_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= 1'b0;
        end else if (if_gnt_o) begin
            rr_ptr_q <= 1'b1;
        end else if (d_gnt_o) begin
            rr_ptr_q <= 1'b0;
        end
    end
`else
    assign pick_if = if_req_i & ~d_req_i;
`endif

    assign pick_d = d_req_i & ~pick_if;

    // Grants are forced low while reset is held so every output reads 0.
    assign if_gnt_o = pick_if & ~reset_i;
    assign d_gnt_o  = pick_d & ~reset_i;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (if_gnt_o) begin
            mem_en_o   = ~if_fault;
            mem_addr_o = if_addr_i[ADDR_W+1:2];
        end else if (d_gnt_o) begin
            mem_en_o    = ~d_fault;
            mem_addr_o  = d_addr_i[ADDR_W+1:2];
            mem_wdata_o = d_wdata_i;
            mem_we_o    = (d_we_i & ~d_fault) ? d_be_i : 4'b0000;
        end
    end

    always_comb begin
        state_d    = StIdle;
        store_d    = 1'b0;
        conflict_d = conflict_q;
        if (if_gnt_o) begin
            state_d = if_fault ? StErrIf : StRespIf;
        end else if (d_gnt_o) begin
            state_d = d_fault ? StErrD : StRespD;
            store_d = d_we_i;
        end
        if (conflict && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // Asynchronous reset drops any in-flight response.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            store_q    <= 1'b0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            conflict_q <= conflict_d;
        end
    end

    assign if_rvalid_o    = (state_q == StRespIf);
    assign if_err_o       = (state_q == StErrIf);
    assign d_rvalid_o     = (state_q == StRespD);
    assign d_err_o        = (state_q == StErrD);
    assign conflict_cnt_o = conflict_q;

    // Fetch words are stored big-endian relative to the core.
    assign if_rdata_o = if_rvalid_o ?
        {mem_rdata_i[7:0], mem_rdata_i[15:8], mem_rdata_i[23:16], mem_rdata_i[31:24]} : 32'h0;
    assign d_rdata_o  = (d_rvalid_o && !store_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 4;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              if_req_i;
    logic [63:0]       if_addr_i;
    logic              if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0]       if_rdata_o;
    logic              d_req_i, d_we_i;
    logic [63:0]       d_addr_i;
    logic [31:0]       d_wdata_i;
    logic [3:0]        d_be_i;
    logic              d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0]       d_rdata_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    logic [CNT_W-1:0]  conflict_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    cache_port_arbiter #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_gnt_o      (if_gnt_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_rdata_o    (if_rdata_o),
        .if_err_o      (if_err_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_be_i        (d_be_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .d_err_o       (d_err_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    // BRAM model: byte-enabled write, registered read-before-write.
    logic [31:0] mem_model [2048];
    logic [31:0] rdata_q;

    always @(posedge clk_i) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) mem_model[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end
            rdata_q <= mem_model[mem_addr_o];
        end
    end
    assign mem_rdata_i = rdata_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_model[i] <= 32'h0;
        mem_model[2] <= 32'h1300_0000;
        reset_i   = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = 64'h8;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = 64'h0;
        d_wdata_i = 32'h0;
        d_be_i    = 4'h0;

        // Reset: grants and all outputs low even with a request pending.
        repeat (2) @(negedge clk_i);
        chk("rst_if_gnt", 64'(if_gnt_o), 64'h0);
        chk("rst_mem_en", 64'(mem_en_o), 64'h0);
        chk("rst_rvalid", 64'(if_rvalid_o), 64'h0);
        chk("rst_cnt", 64'(conflict_cnt_o), 64'h0);
        reset_i  = 1'b0;
        if_req_i = 1'b0;

        // T1: fetch read with byte swap.
        @(negedge clk_i);
        if_req_i = 1'b1; if_addr_i = 64'h8;
        #1;
        chk("t1_if_gnt", 64'(if_gnt_o), 64'h1);
        chk("t1_d_gnt", 64'(d_gnt_o), 64'h0);
        chk("t1_mem_en", 64'(mem_en_o), 64'h1);
        chk("t1_mem_addr", 64'(mem_addr_o), 64'h2);
        chk("t1_mem_we", 64'(mem_we_o), 64'h0);
        @(negedge clk_i);
        if_req_i = 1'b0;
        chk("t1_rvalid", 64'(if_rvalid_o), 64'h1);
        chk("t1_rdata", 64'(if_rdata_o), 64'h0000_0013);
        chk("t1_err", 64'(if_err_o), 64'h0);

        // T2: partial store, then read it back.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h40; d_be_i = 4'b0011;
        d_wdata_i = 32'hAABB_CCDD;
        #1;
        chk("t2_d_gnt", 64'(d_gnt_o), 64'h1);
        chk("t2_mem_we", 64'(mem_we_o), 64'h3);
        chk("t2_mem_addr", 64'(mem_addr_o), 64'h10);
        chk("t2_mem_wdata", 64'(mem_wdata_o), 64'hAABB_CCDD);
        @(negedge clk_i);
        chk("t2_rvalid", 64'(d_rvalid_o), 64'h1);
        chk("t2_rdata", 64'(d_rdata_o), 64'h0);
        chk("t2_mem_word", 64'(mem_model[16]), 64'h0000_CCDD);
        d_we_i = 1'b0;
        #1;
        chk("t2_ld_mem_we", 64'(mem_we_o), 64'h0);
        @(negedge clk_i);
        d_req_i = 1'b0;
        chk("t2_ld_rvalid", 64'(d_rvalid_o), 64'h1);
        chk("t2_ld_rdata", 64'(d_rdata_o), 64'h0000_CCDD);

        // T3: four cycles of conflict.
        if_req_i = 1'b1; if_addr_i = 64'h0;
        d_req_i  = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h4;
        for (int i = 0; i < 4; i++) begin
            logic exp_if;
            exp_if = RR ? ((i % 2) == 0) : 1'b0;
            #1;
            chk($sformatf("t3_if_gnt%0d", i), 64'(if_gnt_o), 64'(exp_if));
            chk($sformatf("t3_d_gnt%0d", i), 64'(d_gnt_o), 64'(!exp_if));
            @(negedge clk_i);
            chk($sformatf("t3_if_rv%0d", i), 64'(if_rvalid_o), 64'(exp_if));
            chk($sformatf("t3_d_rv%0d", i), 64'(d_rvalid_o), 64'(!exp_if));
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
        chk("t3_cnt", 64'(conflict_cnt_o), 64'h4);

        // T4: faults are granted without touching the BRAM.
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'hF; d_addr_i = 64'h2000;
        #1;
        chk("t4_d_gnt", 64'(d_gnt_o), 64'h1);
        chk("t4_st_mem_en", 64'(mem_en_o), 64'h0);
        chk("t4_st_mem_we", 64'(mem_we_o), 64'h0);
        @(negedge clk_i);
        chk("t4_st_err", 64'(d_err_o), 64'h1);
        d_we_i = 1'b0;
        #1;
        chk("t4_ld_mem_en", 64'(mem_en_o), 64'h0);
        @(negedge clk_i);
        d_req_i = 1'b0;
        chk("t4_d_err", 64'(d_err_o), 64'h1);
        chk("t4_d_rvalid", 64'(d_rvalid_o), 64'h0);
        if_req_i = 1'b1; if_addr_i = 64'h6;
        #1;
        chk("t4_if_gnt", 64'(if_gnt_o), 64'h1);
        chk("t4_if_mem_en", 64'(mem_en_o), 64'h0);
        @(negedge clk_i);
        if_req_i = 1'b0;
        chk("t4_if_err", 64'(if_err_o), 64'h1);
        chk("t4_if_rvalid", 64'(if_rvalid_o), 64'h0);

        // T5: reset right after a read grant drops the response.
        if_req_i = 1'b1; if_addr_i = 64'h8;
        #1;
        chk("t5_if_gnt", 64'(if_gnt_o), 64'h1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1; if_req_i = 1'b0;
        #1;
        chk("t5_rst_rvalid", 64'(if_rvalid_o), 64'h0);
        chk("t5_rst_cnt", 64'(conflict_cnt_o), 64'h0);
        chk("t5_rst_mem_en", 64'(mem_en_o), 64'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("t5_post_rvalid", 64'(if_rvalid_o), 64'h0);
        chk("t5_post_err", 64'(if_err_o), 64'h0);
        if_req_i = 1'b1; if_addr_i = 64'h0;
        d_req_i  = 1'b1; d_addr_i = 64'h4;
        #1;
        chk("t5_ptr_if_gnt", 64'(if_gnt_o), 64'(RR));
        chk("t5_ptr_d_gnt", 64'(d_gnt_o), 64'(!RR));

        // T6: counter saturates and holds.
        for (int i = 0; i < 20; i++) @(negedge clk_i);
        chk("t6_cnt_sat", 64'(conflict_cnt_o), 64'hF);
        @(negedge clk_i);
        chk("t6_cnt_hold", 64'(conflict_cnt_o), 64'hF);
        if_req_i = 1'b0; d_req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t6_idle_rvalid", 64'(if_rvalid_o | d_rvalid_o), 64'h0);
        chk("t6_cnt_kept", 64'(conflict_cnt_o), 64'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
